// File: rtl/mcont_pkg.sv
// Shared constants and types for the controller-to-channel-buffer write path.
package mcont_pkg;

   localparam int MCONT_ADDR_BITS = 7;
   localparam int MCONT_PAGE_BITS = 2;
   localparam int MCONT_CHN_BITS  = 4;

   typedef struct packed {
      logic [MCONT_PAGE_BITS-1:0] page;
      logic [MCONT_ADDR_BITS-1:0] word;
   } mcont_waddr_t;

endpackage

// File: rtl/mcont_chnbuf_dly.sv
// N-stage register chain (N >= 1) with asynchronous active-low reset; carries
// the write strobes and data together so they can never slip against each other.
module mcont_chnbuf_dly #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stg_q [STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) stg_q[i] <= '0;
      end else begin
         stg_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) stg_q[i] <= stg_q[i-1];
      end
   end

   assign q_o = stg_q[STAGES-1];

endmodule

// File: rtl/mcont_to_chnbuf_reg.sv
// Per-channel write stage from the controller bus into one channel buffer.
// Optional sticky page-overflow detection is enabled by MCONT_TO_CHNBUF_OVFL_EN.
module mcont_to_chnbuf_reg
   import mcont_pkg::*;
#(
   parameter int CHN_NUMBER  = 0,
   parameter int CHN_LATENCY = 0,
   parameter int ADDR_BITS   = MCONT_ADDR_BITS,
   parameter int PAGE_BITS   = MCONT_PAGE_BITS
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [MCONT_CHN_BITS-1:0]      ext_buf_wchn,
   input  logic                           ext_buf_wr,
   input  logic [63:0]                    ext_buf_wdata,
   input  logic                           ext_buf_wpage_nxt,
   input  logic                           seq_done,
   output logic                           buf_wr_chn,
   output logic [PAGE_BITS+ADDR_BITS-1:0] buf_waddr_chn,
   output logic [63:0]                    buf_wdata_chn,
   output logic                           buf_page_done,
   output logic                           buf_done,
   output logic                           buf_ovfl
);

   localparam int DW = 64;
   localparam int PW = 3 + DW;

   logic                 chn_sel_q;
   logic [PW-1:0]        pipe_in;
   logic [PW-1:0]        pipe_out;
   logic                 wr_out;
   logic                 pg_out;
   logic                 dn_out;
   logic [DW-1:0]        data_out;
   logic [ADDR_BITS-1:0] word_q, word_d;
   logic [PAGE_BITS-1:0] page_q, page_d;

   // Channel number leads the strobes by a cycle, so registering the compare aligns them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) chn_sel_q <= 1'b0;
      else      chn_sel_q <= (ext_buf_wchn == MCONT_CHN_BITS'(CHN_NUMBER));
   end

   assign pipe_in = {chn_sel_q & ext_buf_wr,
                     chn_sel_q & ext_buf_wpage_nxt,
                     chn_sel_q & seq_done,
                     ext_buf_wdata};

   mcont_chnbuf_dly #(
      .WIDTH  (PW),
      .STAGES (CHN_LATENCY + 1)
   ) u_dly (
      .clk   (clk),
      .rst_n (rst),
      .d_i   (pipe_in),
      .q_o   (pipe_out)
   );

   assign {wr_out, pg_out, dn_out, data_out} = pipe_out;

   // A write coinciding with a page advance uses the current address; the advance wins for the update.
   always_comb begin
      word_d = word_q;
      page_d = page_q;
      if (pg_out) begin
         word_d = '0;
         page_d = page_q + PAGE_BITS'(1);
      end else if (wr_out) begin
         word_d = word_q + ADDR_BITS'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_q <= '0;
         page_q <= '0;
      end else begin
         word_q <= word_d;
         page_q <= page_d;
      end
   end

`ifdef MCONT_TO_CHNBUF_OVFL_EN
   logic full_q;
   logic ovfl_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full_q <= 1'b0;
         ovfl_q <= 1'b0;
      end else begin
         if (wr_out && full_q) ovfl_q <= 1'b1;
         if (pg_out)                     full_q <= 1'b0;
         else if (wr_out && (&word_q))   full_q <= 1'b1;
      end
   end

   assign buf_ovfl = ovfl_q;
`else
   assign buf_ovfl = 1'b0;
`endif

   assign buf_wr_chn    = wr_out;
   assign buf_wdata_chn = data_out;
   assign buf_page_done = pg_out;
   assign buf_done      = dn_out;
   assign buf_waddr_chn = {page_q, word_q};

endmodule

// File: tb/tb_mcont_to_chnbuf_reg.sv
// Bench for mcont_to_chnbuf_reg: two instances (latency 0 and 2) on channel 3,
// checked every cycle against an index-based reference model of the input history.
module tb_mcont_to_chnbuf_reg;
   import mcont_pkg::*;

   localparam int MAXC = 4096;
   localparam int CHN  = 3;
`ifdef MCONT_TO_CHNBUF_OVFL_EN
   localparam bit EXP_OVFL = 1'b1;
`else
   localparam bit EXP_OVFL = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  ext_buf_wchn;
   logic        ext_buf_wr;
   logic [63:0] ext_buf_wdata;
   logic        ext_buf_wpage_nxt;
   logic        seq_done;

   logic        o_wr [2];
   logic        o_pg [2];
   logic        o_dn [2];
   logic        o_ovfl [2];
   logic [8:0]  o_addr [2];
   logic [63:0] o_data [2];

   always #5 clk = ~clk;

   mcont_to_chnbuf_reg #(.CHN_NUMBER(CHN), .CHN_LATENCY(0)) u_dut0 (
      .clk(clk), .rst(rst), .ext_buf_wchn(ext_buf_wchn), .ext_buf_wr(ext_buf_wr),
      .ext_buf_wdata(ext_buf_wdata), .ext_buf_wpage_nxt(ext_buf_wpage_nxt), .seq_done(seq_done),
      .buf_wr_chn(o_wr[0]), .buf_waddr_chn(o_addr[0]), .buf_wdata_chn(o_data[0]),
      .buf_page_done(o_pg[0]), .buf_done(o_dn[0]), .buf_ovfl(o_ovfl[0]));

   mcont_to_chnbuf_reg #(.CHN_NUMBER(CHN), .CHN_LATENCY(2)) u_dut2 (
      .clk(clk), .rst(rst), .ext_buf_wchn(ext_buf_wchn), .ext_buf_wr(ext_buf_wr),
      .ext_buf_wdata(ext_buf_wdata), .ext_buf_wpage_nxt(ext_buf_wpage_nxt), .seq_done(seq_done),
      .buf_wr_chn(o_wr[1]), .buf_waddr_chn(o_addr[1]), .buf_wdata_chn(o_data[1]),
      .buf_page_done(o_pg[1]), .buf_done(o_dn[1]), .buf_ovfl(o_ovfl[1]));

   // Input history indexed by the rising edge that sampled it.
   logic [3:0]  in_wchn [MAXC];
   logic        in_wr   [MAXC];
   logic        in_pg   [MAXC];
   logic        in_dn   [MAXC];
   logic [63:0] in_data [MAXC];
   bit          rst_at  [MAXC];

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   int m_word [2];
   int m_page [2];
   bit m_full [2];
   bit m_ovfl [2];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < 2; i++) begin
         int L, n, b;
         bit valid, sel, e_wr, e_pg, e_dn;
         mcont_waddr_t ea;
         L = 2 * i;
         n = cyc;
         if (!rst_at[n]) begin
            chk($sformatf("u%0d_rst_wr", L),   o_wr[i],   0);
            chk($sformatf("u%0d_rst_pg", L),   o_pg[i],   0);
            chk($sformatf("u%0d_rst_dn", L),   o_dn[i],   0);
            chk($sformatf("u%0d_rst_addr", L), o_addr[i], 0);
            chk($sformatf("u%0d_rst_data", L), o_data[i], 0);
            chk($sformatf("u%0d_rst_ovfl", L), o_ovfl[i], 0);
            m_word[i] = 0; m_page[i] = 0; m_full[i] = 0; m_ovfl[i] = 0;
         end else begin
            b = n - L - 1;
            valid = (b >= 1);
            if (valid)
               for (int k = b; k <= n; k++) if (!rst_at[k]) valid = 1'b0;
            sel = 1'b0;
            if (valid) sel = (in_wchn[b] == 4'(CHN));
            e_wr = sel && in_wr[n-L];
            e_pg = sel && in_pg[n-L];
            e_dn = sel && in_dn[n-L];
            ea.page = 2'(m_page[i]);
            ea.word = 7'(m_word[i]);
            chk($sformatf("u%0d_wr", L),   o_wr[i],   e_wr);
            chk($sformatf("u%0d_pg", L),   o_pg[i],   e_pg);
            chk($sformatf("u%0d_dn", L),   o_dn[i],   e_dn);
            chk($sformatf("u%0d_addr", L), o_addr[i], ea);
            chk($sformatf("u%0d_ovfl", L), o_ovfl[i], m_ovfl[i]);
            if (e_wr) chk($sformatf("u%0d_data", L), o_data[i], in_data[n-L]);
`ifdef MCONT_TO_CHNBUF_OVFL_EN
            if (e_wr && m_full[i]) m_ovfl[i] = 1'b1;
`endif
            if (e_pg) begin
               m_full[i] = 1'b0;
               m_word[i] = 0;
               m_page[i] = (m_page[i] + 1) % 4;
            end else if (e_wr) begin
               if (m_word[i] == 127) m_full[i] = 1'b1;
               m_word[i] = (m_word[i] + 1) % 128;
            end
         end
      end
   endtask

   task automatic tick(input logic [3:0] w, input logic wr, input logic [63:0] d,
                       input logic pg, input logic dn);
      if (cyc + 1 >= MAXC) begin
         $display("FAIL cycle_budget cyc=%0d actual=%0d required<%0d", cyc, cyc + 1, MAXC);
         $fatal(1, "cycle budget exhausted");
      end
      ext_buf_wchn = w; ext_buf_wr = wr; ext_buf_wdata = d;
      ext_buf_wpage_nxt = pg; seq_done = dn;
      in_wchn[cyc+1] = w; in_wr[cyc+1] = wr; in_data[cyc+1] = d;
      in_pg[cyc+1] = pg; in_dn[cyc+1] = dn; rst_at[cyc+1] = rst;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle(input logic [3:0] w);
      tick(w, 1'b0, 64'h0, 1'b0, 1'b0);
   endtask

   task automatic wr_beat(input logic [63:0] d, input logic pg, input logic dn);
      tick(4'(CHN), 1'b1, d, pg, dn);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("async_rst_wr",   o_wr[i],   0);
         chk("async_rst_addr", o_addr[i], 0);
         chk("async_rst_data", o_data[i], 0);
         chk("async_rst_pg",   o_pg[i],   0);
         chk("async_rst_dn",   o_dn[i],   0);
         chk("async_rst_ovfl", o_ovfl[i], 0);
      end
      idle(4'(CHN));
      idle(4'(CHN));
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      ext_buf_wchn = '0; ext_buf_wr = 1'b0; ext_buf_wdata = '0;
      ext_buf_wpage_nxt = 1'b0; seq_done = 1'b0;
      @(negedge clk);
      repeat (3) idle(4'd0);
      rst = 1'b1;
      idle(4'(CHN));

      // Four back-to-back writes.
      wr_beat(64'h11, 0, 0);
      chk("t1_wr", o_wr[0], 1); chk("t1_addr", o_addr[0], 0); chk("t1_data", o_data[0], 64'h11);
      wr_beat(64'h22, 0, 0);
      chk("t2_addr", o_addr[0], 1); chk("t2_data", o_data[0], 64'h22);
      wr_beat(64'h33, 0, 0);
      chk("t3_addr", o_addr[0], 2); chk("t3_data", o_data[0], 64'h33);
      chk("t3_l2_wr", o_wr[1], 1); chk("t3_l2_addr", o_addr[1], 0); chk("t3_l2_data", o_data[1], 64'h11);
      wr_beat(64'h44, 0, 0);
      chk("t4_addr", o_addr[0], 3); chk("t4_data", o_data[0], 64'h44);
      chk("t4_l2_addr", o_addr[1], 1); chk("t4_l2_data", o_data[1], 64'h22);
      repeat (3) idle(4'(CHN));

      // Channel interleave: a beat belongs to whichever channel was on the bus the cycle before.
      tick(4'd3, 1, 64'hA0, 0, 0);
      tick(4'd5, 1, 64'hA1, 0, 0);
      chk("ilv_a1_wr", o_wr[0], 1); chk("ilv_a1_addr", o_addr[0], 5); chk("ilv_a1_data", o_data[0], 64'hA1);
      tick(4'd3, 1, 64'hA2, 0, 0);
      chk("ilv_gate", o_wr[0], 0);
      tick(4'd5, 1, 64'hA3, 0, 0);
      tick(4'd5, 1, 64'hA4, 0, 0);
      tick(4'd3, 0, 64'h0, 0, 0);
      repeat (3) idle(4'(CHN));
      chk("ilv_next_addr", o_addr[0], 7);
      chk("ilv_next_addr_l2", o_addr[1], 7);

      // Write with seq_done.
      wr_beat(64'h77, 0, 1);
      chk("done_wr", o_wr[0], 1); chk("done_dn", o_dn[0], 1);
      idle(4'(CHN));
      idle(4'(CHN));
      chk("done_l2_wr", o_wr[1], 1); chk("done_l2_dn", o_dn[1], 1); chk("done_l2_data", o_data[1], 64'h77);
      idle(4'(CHN));

      // Reset in the middle of a burst.
      wr_beat(64'h100, 0, 0);
      wr_beat(64'h101, 0, 0);
      do_reset();
      idle(4'(CHN));
      wr_beat(64'hBEEF, 0, 0);
      chk("post_rst_wr", o_wr[0], 1); chk("post_rst_addr", o_addr[0], 0);
      idle(4'(CHN));
      idle(4'(CHN));
      chk("post_rst_l2_wr", o_wr[1], 1); chk("post_rst_l2_addr", o_addr[1], 0);

      // Four full pages, each closed by a write coinciding with page advance.
      do_reset();
      idle(4'(CHN));
      for (int p = 0; p < 4; p++) begin
         for (int j = 0; j < 128; j++) begin
            wr_beat(64'(p * 1000 + j), 0, 0);
            if (j == 0) chk("pg_first_addr", o_addr[0], 64'(p * 128));
         end
         wr_beat(64'(16'hF00 + p), 1, 0);
         chk("pg_adv_addr", o_addr[0], 64'(p * 128));
         chk("pg_adv_done", o_pg[0], 1);
      end
      wr_beat(64'hABC, 0, 0);
      chk("pg_wrap_addr", o_addr[0], 0);
      repeat (3) idle(4'(CHN));

      // 129 writes with no page advance.
      do_reset();
      idle(4'(CHN));
      repeat (128) wr_beat(64'($urandom), 0, 0);
      wr_beat(64'h129, 0, 0);
      chk("ovfl_before", o_ovfl[0], 0);
      idle(4'(CHN));
      chk("ovfl_rise", o_ovfl[0], EXP_OVFL);
      repeat (5) idle(4'(CHN));
      chk("ovfl_sticky", o_ovfl[0], EXP_OVFL);
      chk("ovfl_sticky_l2", o_ovfl[1], EXP_OVFL);

      // Randomized traffic with occasional resets.
      do_reset();
      idle(4'(CHN));
      for (int it = 0; it < 900; it++) begin
         logic [3:0] w;
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else begin
            case ($urandom_range(0, 3))
               0, 1:    w = 4'(CHN);
               2:       w = 4'd5;
               default: w = 4'($urandom_range(0, 15));
            endcase
            tick(w, ($urandom_range(0, 3) != 0), {$urandom, $urandom},
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
         end
      end
      repeat (4) idle(4'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
